// File: rtl/lzc_pipe.sv
// Two-stage leading-zero / leading-one counter with valid/ready handshakes.
// Define LZC_PIPE_NORM_EN to build the normalising barrel shifter behind out_norm.
module lzc_pipe #(
   parameter int WIDTH = 24,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_allsame,
   output logic [WIDTH-1:0] out_norm
);

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_data_r;
   logic             s1_mode_r;

   logic             out_valid_r;
   logic [CW-1:0]    out_count_r;
   logic             out_allsame_r;
   logic [WIDTH-1:0] out_norm_r;

   logic             s2_load_s;
   logic [WIDTH-1:0] scan_s;
   logic [CW-1:0]    count_s;
   logic             allsame_s;
   logic [WIDTH-1:0] norm_s;

   // Leading-zero count; leading ones are counted by inverting the operand first.
   function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] d);
      logic [CW-1:0] cnt;
      logic          hit;
      cnt = {CW{1'b0}};
      hit = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (hit) begin
            cnt = cnt;
         end else if (d[i]) begin
            hit = 1'b1;
         end else begin
            cnt = cnt + {{(CW-1){1'b0}}, 1'b1};
         end
      end
      return cnt;
   endfunction

   assign s2_load_s = s1_valid_r && (!out_valid_r || out_ready);
   assign in_ready  = !s1_valid_r || s2_load_s;

   // Count stage: operand conditioning and leading-bit count from the S1 register.
   always_comb begin
      scan_s    = s1_mode_r ? ~s1_data_r : s1_data_r;
      count_s   = lead_zeros(scan_s);
      allsame_s = (count_s == CW'(WIDTH));
   end

`ifdef LZC_PIPE_NORM_EN
   // Logarithmic left shifter: stage k shifts by 2**k when count bit k is set.
   logic [WIDTH-1:0] shift_s [0:CW];
   assign shift_s[0] = s1_data_r;
   for (genvar k = 0; k < CW; k++) begin : g_shift
      localparam int AMT = 2 ** k;
      if (AMT >= WIDTH) begin : g_flush
         assign shift_s[k+1] = count_s[k] ? {WIDTH{1'b0}} : shift_s[k];
      end else begin : g_part
         assign shift_s[k+1] = count_s[k] ? {shift_s[k][WIDTH-1-AMT:0], {AMT{1'b0}}}
                                          : shift_s[k];
      end
   end
   assign norm_s = shift_s[CW];
`else
   assign norm_s = {WIDTH{1'b0}};
`endif

   // Stage 1: capture operand and mode whenever the stage can advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {WIDTH{1'b0}};
         s1_mode_r  <= 1'b0;
      end else if (in_ready) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_data_r <= in_data;
            s1_mode_r <= in_mode;
         end
      end
   end

   // Stage 2: result registers, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r   <= 1'b0;
         out_count_r   <= {CW{1'b0}};
         out_allsame_r <= 1'b0;
         out_norm_r    <= {WIDTH{1'b0}};
      end else if (s2_load_s) begin
         out_valid_r   <= 1'b1;
         out_count_r   <= count_s;
         out_allsame_r <= allsame_s;
         out_norm_r    <= norm_s;
      end else if (out_ready) begin
         out_valid_r   <= 1'b0;
      end
   end

   assign out_valid   = out_valid_r;
   assign out_count   = out_count_r;
   assign out_allsame = out_allsame_r;
   assign out_norm    = out_norm_r;

endmodule

// File: tb/tb_lzc_pipe.sv
// Scoreboard bench for lzc_pipe at WIDTH=24; norm expectations follow LZC_PIPE_NORM_EN.
module tb_lzc_pipe;

   localparam int WIDTH = 24;
   localparam int CW    = 5;
`ifdef LZC_PIPE_NORM_EN
   localparam bit NORM_ON = 1'b1;
`else
   localparam bit NORM_ON = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_count;
   logic             out_allsame;
   logic [WIDTH-1:0] out_norm;

   lzc_pipe #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_allsame(out_allsame), .out_norm(out_norm)
   );

   typedef struct {
      logic [CW-1:0]    cnt;
      logic             same;
      logic [WIDTH-1:0] norm;
      int               cyc;
      bit               lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   run_len = 0;
   int   last_run = 0;

   logic             hold_v = 1'b0;
   logic [CW-1:0]    hold_cnt;
   logic             hold_same;
   logic [WIDTH-1:0] hold_norm;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops and compares on every output transfer; checks hold stability under stall.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (out_valid) run_len++;
      else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 64'(out_count), 64'hDEAD);
            end else begin
               e = sb.pop_front();
               chk("count", 64'(out_count), 64'(e.cnt));
               chk("allsame", 64'(out_allsame), 64'(e.same));
               chk("norm", 64'(out_norm), 64'(e.norm));
               if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
            end
         end
         if (out_valid && !out_ready) begin
            if (hold_v) begin
               chk("stall_count", 64'(out_count), 64'(hold_cnt));
               chk("stall_allsame", 64'(out_allsame), 64'(hold_same));
               chk("stall_norm", 64'(out_norm), 64'(hold_norm));
            end
            hold_v    = 1'b1;
            hold_cnt  = out_count;
            hold_same = out_allsame;
            hold_norm = out_norm;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   // Called at a negedge: drives one transaction, waits for acceptance, records expectation.
   task automatic send(input logic [WIDTH-1:0] d, input logic m, input logic [CW-1:0] ec,
                       input logic es, input logic [WIDTH-1:0] en, input bit lat);
      exp_t e;
      int   guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      #1;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
      end else begin
         e.cnt  = ec;
         e.same = es;
         e.norm = NORM_ON ? en : {WIDTH{1'b0}};
         e.cyc  = cyc;
         e.lat  = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_count", 64'(out_count), 64'd0);
      chk("rst_allsame", 64'(out_allsame), 64'd0);
      chk("rst_norm", 64'(out_norm), 64'd0);
      @(negedge clk);

      // Directed vectors, first one issued in the cycle reset is released.
      rst_n = 1'b1;
      send(24'h000001, 1'b0, 5'd23, 1'b0, 24'h800000, 1'b1); idle(3);
      send(24'h800000, 1'b0, 5'd0,  1'b0, 24'h800000, 1'b1); idle(3);
      send(24'h000000, 1'b0, 5'd24, 1'b1, 24'h000000, 1'b1); idle(3);
      send(24'hFFFFFF, 1'b1, 5'd24, 1'b1, 24'h000000, 1'b1); idle(3);
      send(24'hFF0F00, 1'b1, 5'd8,  1'b0, 24'h0F0000, 1'b1); idle(3);
      send(24'h000F00, 1'b0, 5'd12, 1'b0, 24'hF00000, 1'b1); idle(5);

      // Ten back-to-back mixed-mode values.
      send(24'h400000, 1'b0, 5'd1,  1'b0, 24'h800000, 1'b1);
      send(24'h7FFFFF, 1'b1, 5'd0,  1'b0, 24'h7FFFFF, 1'b0);
      send(24'h00FFFF, 1'b0, 5'd8,  1'b0, 24'hFFFF00, 1'b0);
      send(24'hFFFFFE, 1'b1, 5'd23, 1'b0, 24'h000000, 1'b0);
      send(24'h0000F0, 1'b0, 5'd16, 1'b0, 24'hF00000, 1'b0);
      send(24'hC00000, 1'b1, 5'd2,  1'b0, 24'h000000, 1'b0);
      send(24'h123456, 1'b0, 5'd3,  1'b0, 24'h91A2B0, 1'b0);
      send(24'hE12345, 1'b1, 5'd3,  1'b0, 24'h091A28, 1'b0);
      send(24'h000002, 1'b0, 5'd22, 1'b0, 24'h800000, 1'b0);
      send(24'hFFFFFF, 1'b1, 5'd24, 1'b1, 24'h000000, 1'b0);
      idle(5);
      chk("stream_run", 64'(last_run), 64'd10);

      // Stall: fill both stages, then verify in_ready stays low while the output is held.
      out_ready = 1'b0;
      send(24'h000100, 1'b0, 5'd15, 1'b0, 24'h800000, 1'b0);
      send(24'h80FFFF, 1'b1, 5'd1,  1'b0, 24'h01FFFE, 1'b0);
      in_valid = 1'b1; in_data = 24'h0007FF; in_mode = 1'b0;
      repeat (3) begin
         #1;
         chk("in_ready_stall", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(24'h0007FF, 1'b0, 5'd13, 1'b0, 24'hFFE000, 1'b0);
      idle(6);

      // Reset with both stages full: everything in flight is dropped.
      out_ready = 1'b0;
      send(24'h000010, 1'b0, 5'd19, 1'b0, 24'h800000, 1'b0);
      send(24'h300000, 1'b0, 5'd2,  1'b0, 24'hC00000, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_count", 64'(out_count), 64'd0);
      sb.delete();
      idle(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(6);
      send(24'h00FFFF, 1'b1, 5'd0, 1'b0, 24'h00FFFF, 1'b1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      idle(2);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lzc_pipe.md
LZC_PIPE -- requirements
Module: lzc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 24, the data width (legal 2..64).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1) (5 at WIDTH=24), the count width; never overridden.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  input transaction present.
REQ-006 in_ready  out  1  block accepts input this cycle.
REQ-007 in_data  in  WIDTH  operand, bit WIDTH-1 is MSB.
REQ-008 in_mode  in  1  0 = count leading zeros, 1 = count leading ones.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  downstream accepts result.
REQ-011 out_count  out  CW  leading-bit count of the transaction.
REQ-012 out_allsame  out  1  operand contains no terminating bit.
REQ-013 out_norm  out  WIDTH  normalised operand (see Configuration).

Function
REQ-014 SHALL transfer input when in_valid && in_ready and output when out_valid && out_ready.
REQ-015 SHALL be a two-stage pipeline: S1 registers in_data/in_mode; S2 registers count, allsame, norm computed from S1.
REQ-016 SHALL present a result with out_valid high 2 cycles after the accepting edge when unstalled.
REQ-017 S2 SHALL load when S1 valid and (S2 empty or out_ready); S2 valid clears when it drains with nothing entering.
REQ-018 in_ready SHALL equal !S1_valid || S2_load; combinational from out_ready, never from in_valid.
REQ-019 Throughput SHALL be one transaction per cycle when out_ready is held high.
REQ-020 Under stall (out_valid && !out_ready), out_count/out_allsame/out_norm SHALL hold stable; no transaction lost or duplicated.
REQ-021 Mode 0: out_count = number of consecutive 0 bits from MSB down to first 1; mode 1: same with 1 bits / first 0.
REQ-022 When no terminating bit exists, out_count SHALL be WIDTH and out_allsame 1; otherwise out_allsame 0.
REQ-023 in_mode SHALL travel with its data; mixed-mode back-to-back transactions SHALL each use their own mode.
REQ-024 Results SHALL emerge in acceptance order.

Reset
REQ-025 On rst_n low: S1_valid, S2_valid, out_valid = 0; out_count = 0; out_allsame = 0; out_norm = 0; in_ready = 1 one cycle... combinationally as soon as both stages are empty.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; none appear after release.
REQ-027 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro LZC_PIPE_NORM_EN defined: out_norm = S1 data shifted left by count, zero-filled, registered in S2 (WIDTH-bit barrel shifter).
REQ-029 Macro LZC_PIPE_NORM_EN undefined: shifter omitted, out_norm tied to 0; all other behaviour identical.

Verification (WIDTH=24, LZC_PIPE_NORM_EN defined unless noted)
REQ-030 mode 0, data 0x000001 -> count 23, allsame 0, norm 0x800000; data 0x800000 -> count 0, norm 0x800000.
REQ-031 mode 0, data 0x000000 -> count 24, allsame 1, norm 0x000000; mode 1, data 0xFFFFFF -> count 24, allsame 1.
REQ-032 mode 1, data 0xFF0F00 -> count 8, norm 0x0F0000; mode 0, data 0x000F00 -> count 12, norm 0xF00000.
REQ-033 Stream 10 back-to-back values with out_ready=1 -> out_valid high 10 consecutive cycles starting 2 cycles after first accept, in order; then hold out_ready=0 3 cycles -> outputs stable, in_ready drops after both stages fill, no loss.
REQ-034 Assert rst_n low with both stages full -> out_valid 0 and in_ready 1 immediately; no stale result after release.
REQ-035 Macro undefined, data 0x000F00 mode 0 -> count 12, norm 0x000000.
